fix_tag_fifo: RTL and testbench

Parametrised synchronous FIFO for the FIX parser tag path, the next-generation tag buffer. It provides true full/empty at 2^ADDR_WIDTH entries, an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags. It also offers a selectable first-word-fall-through (FWFT) read mode and a synchronous flush. It sits between the tag extractor (writer) and the tag/value matcher (reader).

---
 rtl/fix_fifo_pkg.sv | 11 +
 rtl/fix_fifo_mem.sv | 31 +++
 rtl/fix_tag_fifo.sv | 92 +++++++++
 tb/tb_fix_tag_fifo.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fix_fifo_pkg.sv
// fix_fifo_pkg: shared constants and helpers for the FIX tag FIFO
package fix_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int ptr_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/fix_fifo_mem.sv
// fix_fifo_mem: simple dual-port RAM with a registered, clearable read port
module fix_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Storage array; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register doubles as the FIFO output register and clears to zero
    always_ff @(posedge clk) begin
        if (clr)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fix_tag_fifo.sv
// fix_tag_fifo: FIX tag buffer FIFO with optional first-word-fall-through
module fix_tag_fifo
    import fix_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int FWFT          = FIFO_STD,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  afull_o,
    output logic                  aempty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int             DEPTH    = 1 << ADDR_WIDTH;
    localparam int             PW       = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0]  FULL_CNT = PW'(DEPTH);
    localparam logic [PW-1:0]  AF_CNT   = PW'(AFULL_THRESH);
    localparam logic [PW-1:0]  AE_CNT   = PW'(AEMPTY_THRESH);
    localparam logic [PW-1:0]  ONE      = PW'(1);

    logic [PW-1:0] wptr, rptr, count, count_n;
    logic          vld, vld_n, ovf, udf;
    logic          wr_acc, rd_acc, ram_rd, ram_nonempty, clr;

    // Flag decode and accept/prefetch decisions, all from registered state
    always_comb begin
        full_o       = count == FULL_CNT;
        empty_o      = (FWFT == FIFO_FWFT) ? !vld : count == '0;
        afull_o      = count >= AF_CNT;
        aempty_o     = count <= AE_CNT;
        wr_acc       = wr_en_i && !full_o;
        rd_acc       = rd_en_i && !empty_o;
        ram_nonempty = wptr != rptr;
        ram_rd       = (FWFT == FIFO_FWFT) ? ram_nonempty && (!vld || rd_acc) : rd_acc;
        clr          = !rst || flush_i;
        count_n      = (wr_acc && !rd_acc) ? count + ONE :
                       (rd_acc && !wr_acc) ? count - ONE : count;
        vld_n        = (FWFT == FIFO_FWFT) ? (ram_rd || (vld && !rd_acc)) : rd_acc;
        count_o      = count;
        valid_o      = vld;
        overflow_o   = ovf;
        underflow_o  = udf;
    end

    // Pointers, occupancy, output-valid and sticky error flags
    always_ff @(posedge clk) begin
        if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            vld   <= 1'b0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + ONE;
            if (ram_rd) rptr <= rptr + ONE;
            count <= count_n;
            vld   <= vld_n;
            ovf   <= ovf || (wr_en_i && full_o);
            udf   <= udf || (rd_en_i && empty_o);
        end
    end

    fix_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .clr   (clr),
        .we    (wr_acc && !clr),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (data_i),
        .re    (ram_rd && !clr),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (data_o)
    );

endmodule

// File: tb/tb_fix_tag_fifo.sv
// tb_fix_tag_fifo: queue-model checks of standard and FWFT FIFO instances
module tb_fix_tag_fifo;

    logic       clk = 1'b0, rst = 1'b0, flush = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [7:0] din = 8'h00;
    int         asserts = 0, fails = 0;
    bit         chk_on = 1'b0;

    logic [7:0] s_data, f_data;
    logic [2:0] s_count, f_count;
    logic       s_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
    logic       f_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;

    always #5 clk = ~clk;

    fix_tag_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_std (
        .clk(clk), .rst(rst), .flush_i(flush), .wr_en_i(wr), .data_i(din), .rd_en_i(rd),
        .data_o(s_data), .valid_o(s_valid), .full_o(s_full), .empty_o(s_empty),
        .afull_o(s_afull), .aempty_o(s_aempty), .count_o(s_count),
        .overflow_o(s_ovf), .underflow_o(s_udf)
    );

    fix_tag_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_fw (
        .clk(clk), .rst(rst), .flush_i(flush), .wr_en_i(wr), .data_i(din), .rd_en_i(rd),
        .data_o(f_data), .valid_o(f_valid), .full_o(f_full), .empty_o(f_empty),
        .afull_o(f_afull), .aempty_o(f_aempty), .count_o(f_count),
        .overflow_o(f_ovf), .underflow_o(f_udf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue per instance; FWFT also tracks whether the head is presented
    logic [7:0] sq[$], fq[$];
    logic [7:0] s_md = 8'h00, f_md = 8'h00;
    bit         s_mv, s_mo, s_mu, f_pres, f_mo, f_mu;

    always @(posedge clk) begin
        bit full, wa, ra, fetch;
        int ramn;
        if (!rst || flush) begin
            sq.delete(); fq.delete();
            s_md = 8'h00; f_md = 8'h00;
            s_mv = 0; s_mo = 0; s_mu = 0; f_pres = 0; f_mo = 0; f_mu = 0;
        end else begin
            full = sq.size() == 4;
            wa   = wr && !full;
            ra   = rd && sq.size() != 0;
            s_mo = s_mo || (wr && full);
            s_mu = s_mu || (rd && sq.size() == 0);
            s_mv = ra;
            if (ra) s_md = sq.pop_front();
            if (wa) sq.push_back(din);
            full  = fq.size() == 4;
            wa    = wr && !full;
            ra    = rd && f_pres;
            f_mo  = f_mo || (wr && full);
            f_mu  = f_mu || (rd && !f_pres);
            ramn  = fq.size() - (f_pres ? 1 : 0);
            fetch = ramn > 0 && (!f_pres || ra);
            if (ra) void'(fq.pop_front());
            if (wa) fq.push_back(din);
            f_pres = fetch || (f_pres && !ra);
            if (f_pres) f_md = fq[0];
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("s_count",  32'(s_count), 32'(sq.size()));
            check("s_full",   32'(s_full),  32'(sq.size() == 4));
            check("s_empty",  32'(s_empty), 32'(sq.size() == 0));
            check("s_afull",  32'(s_afull), 32'(sq.size() >= 3));
            check("s_aempty", 32'(s_aempty), 32'(sq.size() <= 1));
            check("s_valid",  32'(s_valid), 32'(s_mv));
            check("s_data",   32'(s_data),  32'(s_md));
            check("s_ovf",    32'(s_ovf),   32'(s_mo));
            check("s_udf",    32'(s_udf),   32'(s_mu));
            check("f_count",  32'(f_count), 32'(fq.size()));
            check("f_full",   32'(f_full),  32'(fq.size() == 4));
            check("f_empty",  32'(f_empty), 32'(!f_pres));
            check("f_afull",  32'(f_afull), 32'(fq.size() >= 3));
            check("f_aempty", 32'(f_aempty), 32'(fq.size() <= 1));
            check("f_valid",  32'(f_valid), 32'(f_pres));
            if (f_pres) check("f_data", 32'(f_data), 32'(f_md));
            check("f_ovf",    32'(f_ovf),   32'(f_mo));
            check("f_udf",    32'(f_udf),   32'(f_mu));
        end
    end

    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic f);
        wr = w; rd = r; din = d; flush = f;
        @(negedge clk);
    endtask

    initial begin
        bit ae_exp [4] = '{1, 0, 0, 0};
        bit af_exp [4] = '{0, 0, 1, 1};
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        check("rst_count", 32'(s_count), 0);
        check("rst_empty", 32'(s_empty), 1);
        check("rst_aempty", 32'(s_aempty), 1);
        check("rst_data", 32'(s_data), 0);
        check("rst_fvalid", 32'(f_valid), 0);
        check("rst_fdata", 32'(f_data), 0);
        rst = 1'b1;

        step(1, 0, 8'h0A, 0); check("fw_lat_n", 32'(f_valid), 0);
        step(1, 0, 8'h0B, 0); check("fw_lat_n1_v", 32'(f_valid), 1); check("fw_lat_n1_d", 32'(f_data), 32'h0A);
        step(1, 0, 8'h0C, 0); check("std_cnt3", 32'(s_count), 3);
        step(0, 1, 8'h00, 0); check("rd_a", 32'(s_data), 32'h0A); check("rd_a_v", 32'(s_valid), 1);
        step(0, 1, 8'h00, 0); check("rd_b", 32'(s_data), 32'h0B);
        step(0, 1, 8'h00, 0); check("rd_c", 32'(s_data), 32'h0C);
        check("rd_cnt0", 32'(s_count), 0); check("rd_empty", 32'(s_empty), 1);

        for (int i = 1; i <= 4; i++) step(1, 0, 8'(i), 0);
        step(1, 0, 8'h05, 0);
        check("ovf_full", 32'(s_full), 1); check("ovf_cnt", 32'(s_count), 4); check("ovf_set", 32'(s_ovf), 1);
        step(0, 0, 8'h00, 0); check("ovf_sticky", 32'(s_ovf), 1);
        step(1, 1, 8'h06, 0); check("full_rw_cnt", 32'(s_count), 3); check("full_rw_d", 32'(s_data), 1);
        for (int i = 2; i <= 4; i++) begin
            step(0, 1, 8'h00, 0);
            check("full_keep", 32'(s_data), 32'(i));
        end

        step(0, 0, 8'h00, 1); check("flush_ovf", 32'(s_ovf), 0);
        step(0, 1, 8'h00, 0); check("udf_rd", 32'(s_udf), 1); check("udf_cnt0", 32'(s_count), 0);
        step(0, 0, 8'h00, 1);
        step(1, 1, 8'h77, 0); check("udf_rw", 32'(s_udf), 1); check("udf_rw_cnt", 32'(s_count), 1);

        step(0, 0, 8'h00, 1);
        step(1, 0, 8'h55, 0); check("fw55_n", 32'(f_valid), 0); check("fw55_cnt", 32'(f_count), 1);
        step(0, 0, 8'h00, 0); check("fw55_v", 32'(f_valid), 1); check("fw55_d", 32'(f_data), 32'h55);
        step(0, 1, 8'h00, 0); check("fw55_pop", 32'(f_valid), 0);
        for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h10 + i), 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h00, 0);
            if (i < 3) begin
                check("fw_stream_v", 32'(f_valid), 1);
                check("fw_stream_d", 32'(f_data), 32'(8'h11 + i));
            end else check("fw_stream_end", 32'(f_valid), 0);
        end

        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 8'(i), 0);
            check("thr_aempty", 32'(s_aempty), 32'(ae_exp[i]));
            check("thr_afull", 32'(s_afull), 32'(af_exp[i]));
        end

        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 8'(8'h20 + i), 0);
            step(0, 1, 8'h00, 0);
            check("wrap_d", 32'(s_data), 32'(8'h20 + i));
        end

        step(0, 0, 8'h00, 1);
        step(0, 1, 8'h00, 0);
        step(1, 0, 8'h31, 0);
        step(1, 0, 8'h32, 0);
        step(1, 1, 8'h33, 1);
        check("fl_cnt", 32'(s_count), 0); check("fl_empty", 32'(s_empty), 1);
        check("fl_valid", 32'(s_valid), 0); check("fl_data", 32'(s_data), 0);
        check("fl_udf", 32'(s_udf), 0); check("fl_afull", 32'(s_afull), 0);
        check("fl_fvalid", 32'(f_valid), 0); check("fl_fdata", 32'(f_data), 0);
        check("fl_fcnt", 32'(f_count), 0);

        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(299) != 0;
            step($urandom_range(99) < 55, $urandom_range(99) < 50, 8'($urandom), $urandom_range(63) == 0);
        end
        rst = 1'b1;
        step(0, 0, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
